// File: rtl/frame_mem_arbiter_if.sv
// Bus bundle for frame_mem_arbiter: video read port, ADC write push port and SRAM pins.
//   slave  : arbiter side (takes requests, drives SRAM strobes)
//   master : environment side (video/ADC requesters and SRAM)
interface frame_mem_arbiter_if #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned FIFO_DEPTH = 8
);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_gnt;
  logic [DATA_W-1:0] vid_rdata;
  logic              adc_wr_valid;
  logic [ADDR_W-1:0] adc_wr_addr;
  logic [DATA_W-1:0] adc_wr_data;
  logic              adc_wr_ready;
  logic [LVL_W-1:0]  fifo_level;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_dq_oe;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_oe_n;
  logic              mem_we_n;

  modport slave (
    input  vid_req, vid_addr, adc_wr_valid, adc_wr_addr, adc_wr_data, mem_rdata,
    output vid_gnt, vid_rdata, adc_wr_ready, fifo_level,
           mem_addr, mem_wdata, mem_dq_oe, mem_oe_n, mem_we_n
  );

  modport master (
    output vid_req, vid_addr, adc_wr_valid, adc_wr_addr, adc_wr_data, mem_rdata,
    input  vid_gnt, vid_rdata, adc_wr_ready, fifo_level,
           mem_addr, mem_wdata, mem_dq_oe, mem_oe_n, mem_we_n
  );
endinterface

// File: rtl/frame_mem_arbiter.sv
// Frame-buffer SRAM arbiter: video reads have priority, ADC writes are buffered in a
// FIFO and drained into idle slots; a starvation counter forces a write after
// STARVE_LIM consecutive lost arbitrations.
// Ports: clk_50 (rising edge), reset (async, active high), bus (frame_mem_arbiter_if.slave).
module frame_mem_arbiter #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned WR_CYCLES  = 2,
  parameter int unsigned STARVE_LIM = 16
) (
  input  logic                 clk_50,
  input  logic                 reset,
  frame_mem_arbiter_if.slave   bus
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned WC_W  = 3;
  localparam int unsigned STV_W = 8;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WS, S_WP, S_WH} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_entry_t;

  wr_entry_t         fifo_q [FIFO_DEPTH];
  wr_entry_t         head;

  state_t            state_q,     state_d;
  logic [LVL_W-1:0]  wr_ptr_q,    wr_ptr_d;
  logic [LVL_W-1:0]  rd_ptr_q,    rd_ptr_d;
  logic [LVL_W-1:0]  level_q,     level_d;
  logic              ready_q,     ready_d;
  logic [WC_W-1:0]   wcnt_q,      wcnt_d;
  logic [STV_W-1:0]  starve_q,    starve_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              dq_oe_q,     dq_oe_d;
  logic              oe_n_q,      oe_n_d;
  logic              we_n_q,      we_n_d;
  logic              gnt_q,       gnt_d;
  logic [DATA_W-1:0] rdata_q,     rdata_d;

  logic push, pop, fifo_ne, force_wr;

  assign head = fifo_q[rd_ptr_q[PTR_W-1:0]];

  // Arbitration, write sequencing and FIFO pointer updates
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    starve_d    = starve_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    dq_oe_d     = dq_oe_q;
    oe_n_d      = oe_n_q;
    we_n_d      = we_n_q;
    gnt_d       = 1'b0;
    rdata_d     = rdata_q;
    pop         = 1'b0;
    push        = bus.adc_wr_valid && ready_q;
    fifo_ne     = (level_q != '0);
    force_wr    = fifo_ne && (starve_q == STV_W'(STARVE_LIM));

    case (state_q)
      S_IDLE: begin
        if (force_wr || (!bus.vid_req && fifo_ne)) begin
          // Head is popped on entry so address/data are already stable in the setup cycle
          state_d     = S_WS;
          pop         = 1'b1;
          mem_addr_d  = head.addr;
          mem_wdata_d = head.data;
          dq_oe_d     = 1'b1;
          starve_d    = '0;
        end else if (bus.vid_req) begin
          state_d    = S_RD;
          mem_addr_d = bus.vid_addr;
          oe_n_d     = 1'b0;
          if (fifo_ne && (starve_q < STV_W'(STARVE_LIM))) begin
            starve_d = starve_q + STV_W'(1);
          end
        end
      end
      S_RD: begin
        rdata_d = bus.mem_rdata;
        gnt_d   = 1'b1;
        oe_n_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_WS: begin
        we_n_d  = 1'b0;
        wcnt_d  = WC_W'(WR_CYCLES - 1);
        state_d = S_WP;
      end
      S_WP: begin
        if (wcnt_q == '0) begin
          we_n_d  = 1'b1;
          state_d = S_WH;
        end else begin
          wcnt_d = wcnt_q - WC_W'(1);
        end
      end
      S_WH: begin
        dq_oe_d = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        dq_oe_d = 1'b0;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
      end
    endcase

    wr_ptr_d = wr_ptr_q + LVL_W'(push);
    rd_ptr_d = rd_ptr_q + LVL_W'(pop);
    level_d  = wr_ptr_d - rd_ptr_d;
    ready_d  = (level_d < LVL_W'(FIFO_DEPTH));
  end

  // State and registered outputs
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      ready_q     <= 1'b1;
      wcnt_q      <= '0;
      starve_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      dq_oe_q     <= 1'b0;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      gnt_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      ready_q     <= ready_d;
      wcnt_q      <= wcnt_d;
      starve_q    <= starve_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      dq_oe_q     <= dq_oe_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      gnt_q       <= gnt_d;
      rdata_q     <= rdata_d;
    end
  end

  // FIFO storage; emptiness is governed by the pointers alone
  always_ff @(posedge clk_50) begin
    if (push) begin
      fifo_q[wr_ptr_q[PTR_W-1:0]] <= '{addr: bus.adc_wr_addr, data: bus.adc_wr_data};
    end
  end

  assign bus.vid_gnt      = gnt_q;
  assign bus.vid_rdata    = rdata_q;
  assign bus.adc_wr_ready = ready_q;
  assign bus.fifo_level   = level_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.mem_dq_oe    = dq_oe_q;
  assign bus.mem_oe_n     = oe_n_q;
  assign bus.mem_we_n     = we_n_q;

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// Self-checking bench for frame_mem_arbiter: transaction-level model (write scoreboard,
// FIFO occupancy, lost-arbitration count, read data pattern) plus directed scenarios.
module tb_frame_mem_arbiter;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned WRC   = 2;
  localparam int unsigned SLIM  = 16;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] d;
  } wr_t;

  logic clk_50 = 1'b0;
  logic reset;
  always #10 clk_50 = ~clk_50;

  frame_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16), .FIFO_DEPTH(DEPTH)) bus ();

  frame_mem_arbiter #(
    .ADDR_W(16), .DATA_W(16), .FIFO_DEPTH(DEPTH), .WR_CYCLES(WRC), .STARVE_LIM(SLIM)
  ) dut (
    .clk_50 (clk_50),
    .reset  (reset),
    .bus    (bus)
  );

  int n_chk = 0;
  int n_bad = 0;

  function automatic logic [15:0] pat(input logic [15:0] a);
    return a ^ 16'hA54A;
  endfunction

  // SRAM read model: drives the pattern only while output enable is active
  assign bus.mem_rdata = bus.mem_oe_n ? 16'h0000 : pat(bus.mem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model / monitor ----------------
  wr_t         exp_q[$];
  wr_t         wlog[$];
  wr_t         p_ent, cur_wr, e;
  int          lvl_m, lost_m, lvl_before;
  int          wr_cyc, wr_low;
  bit          wr_stable;
  bit          p_push, p_vreq;
  bit          prev_dq, prev_oen, prev_wen;
  logic [15:0] rd_exp, last_rdata;

  always @(posedge clk_50) begin
    p_push = bus.adc_wr_valid && bus.adc_wr_ready && !reset;
    p_ent  = '{a: bus.adc_wr_addr, d: bus.adc_wr_data};
    p_vreq = bus.vid_req;
    #1;
    if (reset) begin
      exp_q.delete();
      lvl_m = 0; lost_m = 0;
      prev_dq = 1'b0; prev_oen = 1'b1; prev_wen = 1'b1;
      last_rdata = 16'h0;
      chk("rst_strobes", {27'd0, bus.mem_oe_n, bus.mem_we_n, bus.mem_dq_oe, bus.vid_gnt, bus.adc_wr_ready},
          32'b11001);
      chk("rst_addr_data", {bus.mem_addr, bus.mem_wdata}, 32'h0);
      chk("rst_rdata_level", {12'd0, bus.vid_rdata, bus.fifo_level}, 32'h0);
    end else begin
      lvl_before = lvl_m;
      if (p_push) begin
        exp_q.push_back(p_ent);
        lvl_m++;
      end
      if (bus.mem_dq_oe && !prev_dq) begin
        chk("wr_setup_we", {31'd0, bus.mem_we_n}, 32'd1);
        if (exp_q.size() == 0) chk("wr_unexpected", 32'd0, 32'd1);
        else begin
          e = exp_q.pop_front();
          chk("wr_order", {bus.mem_addr, bus.mem_wdata}, e);
        end
        lvl_m--;
        if (p_vreq) chk("wr_forced_after_lim", lost_m, SLIM);
        lost_m = 0;
        wr_cyc = 0; wr_low = 0; wr_stable = 1'b1;
        cur_wr = '{a: bus.mem_addr, d: bus.mem_wdata};
      end
      if (bus.mem_dq_oe) begin
        wr_cyc++;
        if (!bus.mem_we_n) wr_low++;
        if ({bus.mem_addr, bus.mem_wdata} != cur_wr) wr_stable = 1'b0;
      end
      if (!bus.mem_dq_oe && prev_dq) begin
        chk("wr_shape", {wr_cyc[7:0], wr_low[7:0], 7'd0, wr_stable, 7'd0, prev_wen},
            {8'(2 + WRC), 8'(WRC), 16'h0101});
        wlog.push_back(cur_wr);
      end
      if (!bus.mem_oe_n && prev_oen) begin
        if (lvl_before > 0) begin
          chk("rd_starve_bound", {31'd0, (lost_m < SLIM)}, 32'd1);
          lost_m++;
        end
        chk("rd_addr", bus.mem_addr, bus.vid_addr);
        rd_exp = pat(bus.vid_addr);
      end
      chk("oe_len", {31'd0, (!bus.mem_oe_n && !prev_oen)}, 32'd0);
      chk("gnt_timing", bus.vid_gnt, !prev_oen);
      if (bus.vid_gnt) chk("rd_data", bus.vid_rdata, rd_exp);
      else chk("rd_hold", bus.vid_rdata, last_rdata);
      last_rdata = bus.vid_rdata;
      chk("excl", {30'd0, (!bus.mem_oe_n && bus.mem_dq_oe), (!bus.mem_we_n && !bus.mem_dq_oe)}, 32'd0);
      chk("level", bus.fifo_level, lvl_m);
      chk("ready", bus.adc_wr_ready, (lvl_m < DEPTH));
      prev_dq  = bus.mem_dq_oe;
      prev_oen = bus.mem_oe_n;
      prev_wen = bus.mem_we_n;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push(input logic [15:0] a, input logic [15:0] d);
    int n = 0;
    @(negedge clk_50);
    bus.adc_wr_valid = 1'b1; bus.adc_wr_addr = a; bus.adc_wr_data = d;
    while (!bus.adc_wr_ready && n < 200) begin
      @(negedge clk_50);
      n++;
    end
    if (n >= 200) chk("push_timeout", 32'd1, 32'd0);
    @(posedge clk_50);
    #1 bus.adc_wr_valid = 1'b0;
  endtask

  task automatic do_read(input string name, input logic [15:0] a, input int exp_lat,
                         input logic [15:0] exp_data);
    int lat = 0;
    @(negedge clk_50);
    bus.vid_addr = a; bus.vid_req = 1'b1;
    do begin
      @(posedge clk_50);
      #1 lat++;
    end while (!bus.vid_gnt && lat < 20);
    chk({name, "_latency"}, lat, exp_lat);
    chk({name, "_rdata"}, bus.vid_rdata, exp_data);
    bus.vid_req = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    @(negedge clk_50);
    while (!(bus.fifo_level == '0 && !bus.mem_dq_oe) && n < 400) begin
      @(negedge clk_50);
      n++;
    end
    chk({name, "_drain_level"}, bus.fifo_level, 32'd0);
    chk({name, "_drain_dq"}, bus.mem_dq_oe, 32'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int base, idx, resumed, n;
    bit full_seen;
    reset = 1'b1;
    bus.vid_req = 1'b0; bus.vid_addr = '0;
    bus.adc_wr_valid = 1'b0; bus.adc_wr_addr = '0; bus.adc_wr_data = '0;
    repeat (3) @(negedge clk_50);
    chk("t0_ready", bus.adc_wr_ready, 32'd1);
    reset = 1'b0;
    @(negedge clk_50);

    // 1: single read
    do_read("t1", 16'h0010, 2, 16'hA55A);
    repeat (2) @(negedge clk_50);

    // 2: three buffered writes with video idle
    base = wlog.size();
    push(16'h0100, 16'h1111);
    push(16'h0101, 16'h2222);
    push(16'h0102, 16'h3333);
    wait_drain("t2");
    chk("t2_count", wlog.size() - base, 32'd3);
    if (wlog.size() >= base + 3) begin
      chk("t2_w0", wlog[base],     32'h0100_1111);
      chk("t2_w1", wlog[base + 1], 32'h0101_2222);
      chk("t2_w2", wlog[base + 2], 32'h0102_3333);
    end

    // 3: nine pushes under continuous video; FIFO fills, writes forced by starvation
    base = wlog.size(); idx = 0; resumed = 0; full_seen = 1'b0;
    @(negedge clk_50);
    bus.vid_addr = 16'h0400; bus.vid_req = 1'b1;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk_50);
      if (bus.vid_gnt) begin
        bus.vid_addr = bus.vid_addr + 16'd1;
        if (wlog.size() == base + 1) resumed++;
      end
      if (idx == 8 && !full_seen) begin
        chk("t3_full_level", bus.fifo_level, 32'd8);
        chk("t3_full_ready", bus.adc_wr_ready, 32'd0);
        full_seen = 1'b1;
      end
      if (idx < 9) begin
        bus.adc_wr_valid = 1'b1;
        bus.adc_wr_addr  = 16'h0300 + 16'(idx);
        bus.adc_wr_data  = 16'hC000 + 16'(idx);
        if (bus.adc_wr_ready) idx++;
      end else bus.adc_wr_valid = 1'b0;
      if (wlog.size() >= base + 2) bus.vid_req = 1'b0;
      if (idx == 9 && !bus.vid_req) break;
    end
    @(negedge clk_50);
    bus.adc_wr_valid = 1'b0; bus.vid_req = 1'b0;
    chk("t3_pushed", idx, 32'd9);
    chk("t3_video_resumed", {31'd0, (resumed > 0)}, 32'd1);
    wait_drain("t3");
    chk("t3_count", wlog.size() - base, 32'd9);
    if (wlog.size() >= base + 9) chk("t3_last", wlog[base + 8], 32'h0308_C008);

    // 4: push and pop in the same cycle at level 4, then wrap with 20 writes total
    base = wlog.size(); idx = 0;
    @(negedge clk_50);
    bus.vid_addr = 16'h0500; bus.vid_req = 1'b1;
    for (int c = 0; c < 50 && idx < 4; c++) begin
      @(negedge clk_50);
      bus.adc_wr_valid = 1'b1;
      bus.adc_wr_addr  = 16'h0200 + 16'(idx);
      bus.adc_wr_data  = 16'hB000 + 16'(idx);
      if (bus.adc_wr_ready) idx++;
    end
    @(negedge clk_50);
    bus.adc_wr_valid = 1'b0;
    n = 0;
    while (!bus.vid_gnt && n < 20) begin
      @(negedge clk_50);
      n++;
    end
    chk("t4_pre_level", bus.fifo_level, 32'd4);
    bus.vid_req = 1'b0;
    bus.adc_wr_valid = 1'b1; bus.adc_wr_addr = 16'h0204; bus.adc_wr_data = 16'hB004;
    @(posedge clk_50);
    #1 bus.adc_wr_valid = 1'b0;
    chk("t4_pushpop_level", bus.fifo_level, 32'd4);
    chk("t4_pop_started", bus.mem_dq_oe, 32'd1);
    for (int i = 5; i < 20; i++) push(16'h0200 + 16'(i), 16'hB000 + 16'(i));
    wait_drain("t4");
    chk("t4_count", wlog.size() - base, 32'd20);
    if (wlog.size() >= base + 20) begin
      chk("t4_w4",  wlog[base + 4],  32'h0204_B004);
      chk("t4_w19", wlog[base + 19], 32'h0213_B013);
    end

    // 5: reset in the middle of the write pulse
    push(16'h0600, 16'hD00D);
    n = 0;
    do begin
      @(posedge clk_50);
      #1 n++;
    end while (bus.mem_we_n && n < 20);
    chk("t5_in_pulse", bus.mem_we_n, 32'd0);
    #3 reset = 1'b1;
    #1;
    chk("t5_we_n", bus.mem_we_n, 32'd1);
    chk("t5_dq_oe", bus.mem_dq_oe, 32'd0);
    chk("t5_level", bus.fifo_level, 32'd0);
    chk("t5_ready", bus.adc_wr_ready, 32'd1);
    repeat (2) @(negedge clk_50);
    reset = 1'b0;
    do_read("t5_read", 16'h0020, 2, 16'hA56A);
    repeat (2) @(negedge clk_50);

    // 6: video request arriving during write setup waits for the whole write
    push(16'h0700, 16'hE00E);
    n = 0;
    do begin
      @(posedge clk_50);
      #1 n++;
    end while (!(bus.mem_dq_oe && bus.mem_we_n) && n < 20);
    chk("t6_in_setup", {bus.mem_dq_oe, bus.mem_we_n}, 32'b11);
    do_read("t6", 16'h0030, 6, 16'hA57A);
    repeat (3) @(negedge clk_50);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
